// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, single-outstanding instruction fetch, and a small
// instruction queue feeding decode. Redirects flush the queue and discard any
// response that belongs to the pre-redirect path.
module fetch_unit #(
   parameter int             N        = 64,
   parameter int             DEPTH    = 4,
   parameter logic [N-1:0]   RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       PCSrc_F,
   input  logic [N-1:0]               PCBranch_F,
   output logic                       imem_req,
   output logic [N-1:0]               imem_addr_F,
   input  logic                       imem_gnt,
   input  logic                       imem_rvalid,
   input  logic [31:0]                imem_rdata,
   output logic                       instr_valid_D,
   output logic [31:0]                instr_D,
   output logic [N-1:0]               pc_D,
   input  logic                       instr_ready_D,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]    r_state;
   logic [N-1:0]  r_pc;
   logic [N-1:0]  r_pend_pc;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_q_instr [DEPTH];
   logic [N-1:0]  r_q_pc    [DEPTH];

   logic          w_fire;
   logic          w_push;
   logic          w_pop;
   logic [N-1:0]  w_tgt;

   // Word-align the redirect target (low two bits are dropped).
   assign w_tgt = PCBranch_F & ~N'(3);

   // Requests are held off during reset, on redirect, while a request is
   // outstanding, and when the queue has no free slot for the response.
   assign imem_req    = reset & (r_state == S_REQ) & ~PCSrc_F & (r_count < CW'(DEPTH));
   assign imem_addr_F = r_pc;
   assign w_fire      = imem_req & imem_gnt;
   assign w_push      = (r_state == S_WAIT) & imem_rvalid & ~PCSrc_F;
   assign w_pop       = instr_valid_D & instr_ready_D;

   assign instr_valid_D = (r_count != '0);
   assign instr_D       = r_q_instr[r_rptr];
   assign pc_D          = r_q_pc[r_rptr];
   assign count         = r_count;

   // PC, pending-PC and request FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_REQ;
         r_pc      <= RESET_PC;
         r_pend_pc <= '0;
      end else begin
         if (PCSrc_F)
            r_pc <= w_tgt;
         else if (w_fire)
            r_pc <= r_pc + N'(4);
         if (w_fire)
            r_pend_pc <= r_pc;
         case (r_state)
            S_REQ:   if (w_fire) r_state <= S_WAIT;
            // A redirect with no response yet leaves a stale response in flight.
            S_WAIT:  if (imem_rvalid) r_state <= S_REQ;
                     else if (PCSrc_F) r_state <= S_DROP;
            S_DROP:  if (imem_rvalid) r_state <= S_REQ;
            default: r_state <= S_REQ;
         endcase
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue outright.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (PCSrc_F) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Queue storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_instr[r_wptr] <= imem_rdata;
         r_q_pc[r_wptr]    <= r_pend_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus against a transaction-level
// model (PC value, pending-response tag, queue of {pc, instr}).
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        PCSrc_F = 1'b0;
   logic [63:0] PCBranch_F = '0;
   logic        imem_req;
   logic [63:0] imem_addr_F;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid_D;
   logic [31:0] instr_D;
   logic [63:0] pc_D;
   logic        instr_ready_D = 1'b0;
   logic [2:0]  count;

   // narrow-PC instance for wrap-around
   logic        rst8 = 1'b0, pcsrc8 = 1'b0, gnt8 = 1'b0;
   logic [7:0]  tgt8 = '0;
   logic        req8, vld8;
   logic [7:0]  addr8, pcd8;
   logic [31:0] ins8;
   logic [2:0]  cnt8;

   fetch_unit #(.N(64), .DEPTH(DEPTH), .RESET_PC(64'h0)) u_dut (
      .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
      .imem_req(imem_req), .imem_addr_F(imem_addr_F), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid_D(instr_valid_D), .instr_D(instr_D), .pc_D(pc_D),
      .instr_ready_D(instr_ready_D), .count(count));

   fetch_unit #(.N(8), .DEPTH(4), .RESET_PC(8'h0)) u_dut8 (
      .clk(clk), .reset(rst8), .PCSrc_F(pcsrc8), .PCBranch_F(tgt8),
      .imem_req(req8), .imem_addr_F(addr8), .imem_gnt(gnt8),
      .imem_rvalid(1'b0), .imem_rdata(32'h0),
      .instr_valid_D(vld8), .instr_D(ins8), .pc_D(pcd8),
      .instr_ready_D(1'b1), .count(cnt8));

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   int n_chk = 0;
   int n_pass = 0;

   // model state
   ent_t        mq[$];
   logic [63:0] m_pc;
   logic [63:0] m_pend_pc;
   int          m_pend;      // 0 none, 1 live response due, 2 stale response due
   // memory responder
   bit          mem_busy;
   int          mem_wait;
   logic [63:0] mem_addr;
   int          lat_min = 0, lat_max = 0;
   bit          spur_en = 0;
   // last sampled outputs
   logic        s_req, s_vld;
   logic [63:0] s_addr, s_pcd;
   logic [2:0]  s_count;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] mdata(input logic [63:0] a);
      return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A1234 ^ a[63:32];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; PCSrc_F = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready_D = 1'b0;
      #1;
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_vld", 64'(instr_valid_D), 64'd0);
      chk("rst_cnt", 64'(count), 64'd0);
      chk("rst_addr", imem_addr_F, 64'h0);
      mq.delete(); m_pc = 64'h0; m_pend = 0; m_pend_pc = '0; mem_busy = 0; mem_wait = 0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel_req", 64'(imem_req), 64'd1);
      chk("rel_addr", imem_addr_F, 64'h0);
   endtask

   task automatic step(input bit pcsrc, input logic [63:0] tgt, input bit gnt, input bit rdy);
      bit rv, e_req, e_vld;
      logic [31:0] rd;
      logic [63:0] pc0;
      @(negedge clk);
      rv = 0; rd = $urandom;
      if (mem_busy) begin
         if (mem_wait == 0) begin rv = 1; rd = mdata(mem_addr); end
      end else if (spur_en && $urandom_range(0, 7) == 0) rv = 1;
      PCSrc_F = pcsrc; PCBranch_F = tgt; imem_gnt = gnt; imem_rvalid = rv;
      imem_rdata = rd; instr_ready_D = rdy;
      #1;
      e_req = (m_pend == 0) && !pcsrc && (mq.size() < DEPTH);
      e_vld = (mq.size() != 0);
      chk("req", 64'(imem_req), 64'(e_req));
      chk("addr", imem_addr_F, m_pc);
      chk("vld", 64'(instr_valid_D), 64'(e_vld));
      chk("count", 64'(count), 64'(mq.size()));
      if (e_vld) begin
         chk("pc_D", pc_D, mq[0].pc);
         chk("instr_D", 64'(instr_D), 64'(mq[0].ins));
      end
      s_req = imem_req; s_addr = imem_addr_F; s_vld = instr_valid_D;
      s_pcd = pc_D; s_count = count;
      // model update for the coming edge
      pc0 = m_pc;
      if (e_vld && rdy) void'(mq.pop_front());
      if (pcsrc) begin
         mq.delete();
         m_pc = {tgt[63:2], 2'b00};
         if (m_pend != 0) m_pend = rv ? 0 : 2;
      end else begin
         if (m_pend == 1 && rv) begin
            mq.push_back('{pc: m_pend_pc, ins: rd});
            m_pend = 0;
         end else if (m_pend == 2 && rv) m_pend = 0;
         if (e_req && gnt) begin
            m_pend_pc = m_pc; m_pc = m_pc + 64'd4; m_pend = 1;
         end
      end
      if (mem_busy) begin
         if (mem_wait == 0) mem_busy = 0; else mem_wait--;
      end
      if (e_req && gnt) begin
         mem_busy = 1; mem_addr = pc0; mem_wait = $urandom_range(lat_min, lat_max);
      end
   endtask

   initial begin
      bit seen;

      // wrap-around on an 8-bit PC
      @(negedge clk);
      rst8 = 1'b1; pcsrc8 = 1'b1; tgt8 = 8'hFE;
      @(negedge clk);
      pcsrc8 = 1'b0; gnt8 = 1'b1;
      #1;
      chk("wrap_req", 64'(req8), 64'd1);
      chk("wrap_pre", 64'(addr8), 64'hFC);
      @(negedge clk);
      gnt8 = 1'b0;
      #1;
      chk("wrap_post", 64'(addr8), 64'h00);

      // streaming: one-cycle latency, always ready
      lat_min = 0; lat_max = 0; spur_en = 0;
      do_reset();
      repeat (24) step(0, 64'h0, 1, 1);

      // back-pressure: queue fills to DEPTH, then one pop re-opens requests
      do_reset();
      repeat (12) step(0, 64'h0, 1, 0);
      chk("bp_count", 64'(s_count), 64'd4);
      chk("bp_req", 64'(s_req), 64'd0);
      step(0, 64'h0, 1, 1);
      step(0, 64'h0, 1, 0);
      chk("bp_count3", 64'(s_count), 64'd3);
      chk("bp_req3", 64'(s_req), 64'd1);

      // redirect while waiting: stale response dropped
      lat_min = 2; lat_max = 2;
      do_reset();
      step(0, 64'h0, 1, 1);
      step(1, 64'h1003, 0, 1);
      step(0, 64'h0, 1, 1);
      step(0, 64'h0, 1, 1);
      step(0, 64'h0, 1, 1);
      chk("rw_req", 64'(s_req), 64'd1);
      chk("rw_addr", s_addr, 64'h1000);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(0, 64'h0, 0, 0);
         if (s_vld) begin seen = 1; chk("rw_first_pc", s_pcd, 64'h1000); end
      end
      if (!seen) chk("rw_timeout", 64'd0, 64'd1);

      // redirect coincident with response and a pop at count=2
      lat_min = 0; lat_max = 0;
      do_reset();
      repeat (5) step(0, 64'h0, 1, 0);
      chk("co_cnt2", 64'(s_count), 64'd2);
      step(1, 64'h2000, 1, 1);
      step(0, 64'h0, 0, 0);
      chk("co_cnt0", 64'(s_count), 64'd0);
      chk("co_req", 64'(s_req), 64'd1);
      chk("co_addr", s_addr, 64'h2000);

      // randomized traffic with spurious responses and mid-flight resets
      lat_min = 0; lat_max = 3; spur_en = 1;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         step($urandom_range(0, 15) == 0, {$urandom, $urandom},
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
